instr_fetch_queue: RTL and testbench

- Instruction fetch queue sitting directly upstream of the MIPS_Processor IF stage.
- Accepts 32-bit instruction words from the stimulus source through a valid/ready handshake.
- Buffers them in a small FIFO and tags each word with its PC.
- Presents the head word to the pipeline; honours hazard-unit freeze and branch-taken flush.
- When nothing is valid, emits NOP (all zeros) so the pipeline receives bubbles.

---
 rtl/instr_fetch_queue_if.sv | 30 +++
 rtl/instr_fetch_queue.sv | 92 +++++++++
 tb/tb_instr_fetch_queue.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_queue_if.sv
// Handshake/bus bundle between the instruction source, the fetch queue and the IF stage.
// The source drives the master side and the queue takes the slave side.
interface instr_fetch_queue_if #(
   parameter int INSTR_WIDTH = 32,
   parameter int PC_WIDTH    = 32,
   parameter int DEPTH       = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [INSTR_WIDTH-1:0] instr_in;
   logic                   instr_valid_in;
   logic                   instr_ready_out;
   logic                   freeze;
   logic                   flush;
   logic [PC_WIDTH-1:0]    branch_target;
   logic [INSTR_WIDTH-1:0] instr_out;
   logic [PC_WIDTH-1:0]    pc_out;
   logic                   instr_valid_out;
   logic [CW-1:0]          count_out;

   modport master (
      output instr_in, instr_valid_in, freeze, flush, branch_target,
      input  instr_ready_out, instr_out, pc_out, instr_valid_out, count_out
   );

   modport slave (
      input  instr_in, instr_valid_in, freeze, flush, branch_target,
      output instr_ready_out, instr_out, pc_out, instr_valid_out, count_out
   );
endinterface

// File: rtl/instr_fetch_queue.sv
// Show-ahead instruction FIFO in front of the IF stage: tags words with their PC,
// holds the head on freeze, empties on flush and emits NOP bubbles when empty.
module instr_fetch_queue #(
   parameter int INSTR_WIDTH = 32,
   parameter int PC_WIDTH    = 32,
   parameter int DEPTH       = 4,
   parameter int PC_STEP     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   instr_fetch_queue_if.slave   fq
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [INSTR_WIDTH-1:0] instr_mem_q [DEPTH];
   logic [INSTR_WIDTH-1:0] instr_mem_d [DEPTH];
   logic [PC_WIDTH-1:0]    pc_mem_q [DEPTH];
   logic [PC_WIDTH-1:0]    pc_mem_d [DEPTH];
   logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]          count_q, count_d;
   logic [PC_WIDTH-1:0]    push_pc_q, push_pc_d;
   logic                   ready;
   logic                   valid;
   logic                   push;
   logic                   pop;

   // Ready depends only on registered occupancy, so a full queue never passes a word through.
   always_comb begin
      ready = (count_q < DEPTH_C);
      valid = (count_q != '0);
      push  = fq.instr_valid_in && ready && !fq.flush;
      pop   = valid && !fq.freeze && !fq.flush;

      instr_mem_d = instr_mem_q;
      pc_mem_d    = pc_mem_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      push_pc_d   = push_pc_q;

      if (fq.flush) begin
         rd_ptr_d  = '0;
         wr_ptr_d  = '0;
         count_d   = '0;
         push_pc_d = fq.branch_target;
      end else begin
         if (push) begin
            instr_mem_d[wr_ptr_q] = fq.instr_in;
            pc_mem_d[wr_ptr_q]    = push_pc_q;
            wr_ptr_d              = wr_ptr_q + AW'(1);
            push_pc_d             = push_pc_q + PC_WIDTH'(PC_STEP);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CW'(1);
         end else if (pop && !push) begin
            count_d = count_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         instr_mem_q <= '{default: '0};
         pc_mem_q    <= '{default: '0};
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         push_pc_q   <= '0;
      end else begin
         instr_mem_q <= instr_mem_d;
         pc_mem_q    <= pc_mem_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         push_pc_q   <= push_pc_d;
      end
   end

   always_comb begin
      fq.instr_ready_out = ready;
      fq.instr_valid_out = valid;
      fq.count_out       = count_q;
      fq.instr_out       = valid ? instr_mem_q[rd_ptr_q] : '0;
      fq.pc_out          = valid ? pc_mem_q[rd_ptr_q] : '0;
   end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed vector table followed by randomized traffic
// compared against a queue-based reference model.
module tb_instr_fetch_queue;
   logic clk;
   logic rst;

   instr_fetch_queue_if #(.INSTR_WIDTH(32), .PC_WIDTH(32), .DEPTH(4)) bus ();

   instr_fetch_queue #(.INSTR_WIDTH(32), .PC_WIDTH(32), .DEPTH(4), .PC_STEP(4)) dut (
      .clk (clk),
      .rst (rst),
      .fq  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        r;
      logic        vin;
      logic [31:0] ins;
      logic        frz;
      logic        fl;
      logic [31:0] bt;
      logic        ev;
      logic [31:0] ei;
      logic [31:0] ep;
      int          ec;
      logic        er;
   } vec_t;

   typedef struct {
      logic [31:0] i;
      logic [31:0] p;
   } ent_t;

   vec_t vecs[$];
   ent_t mq[$];
   int   tests = 0;
   int   fails = 0;

   function automatic void add(logic r, logic vin, logic [31:0] ins, logic frz, logic fl,
                               logic [31:0] bt, logic ev, logic [31:0] ei, logic [31:0] ep,
                               int ec, logic er);
      vec_t v;
      v.r = r; v.vin = vin; v.ins = ins; v.frz = frz; v.fl = fl; v.bt = bt;
      v.ev = ev; v.ei = ei; v.ep = ep; v.ec = ec; v.er = er;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic vin, input logic [31:0] ins,
                        input logic frz, input logic fl, input logic [31:0] bt);
      rst                = r;
      bus.instr_valid_in = vin;
      bus.instr_in       = ins;
      bus.freeze         = frz;
      bus.flush          = fl;
      bus.branch_target  = bt;
      @(posedge clk);
      #1;
   endtask

   task automatic check_outputs(input string tag, input logic ev, input logic [31:0] ei,
                                input logic [31:0] ep, input int ec, input logic er);
      chk({tag, "_valid"}, 32'(bus.instr_valid_out), 32'(ev));
      chk({tag, "_instr"}, bus.instr_out, ei);
      chk({tag, "_pc"},    bus.pc_out, ep);
      chk({tag, "_count"}, 32'(bus.count_out), 32'(ec));
      chk({tag, "_ready"}, 32'(bus.instr_ready_out), 32'(er));
   endtask

   initial begin
      logic        r, vin, frz, fl, mready, mvalid;
      logic [31:0] ins, bt, mpc;
      ent_t        e;

      // reset, then a three-word stream with no freeze
      add(0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 1);
      add(1, 1, 32'h0A002080, 0, 0, 0,  1, 32'h0A002080, 32'h0, 1, 1);
      add(1, 1, 32'h00084004, 0, 0, 0,  1, 32'h00084004, 32'h4, 1, 1);
      add(1, 1, 32'h0008600C, 0, 0, 0,  1, 32'h0008600C, 32'h8, 1, 1);
      add(1, 0, 0, 0, 0, 0,             0, 0, 0, 0, 1);
      // fill under freeze, refused fifth word, then drain
      add(0, 0, 0, 0, 0, 0,             0, 0, 0, 0, 1);
      add(1, 1, 32'h00188214, 1, 0, 0,  1, 32'h00188214, 32'h0, 1, 1);
      add(1, 1, 32'h3402A084, 1, 0, 0,  1, 32'h00188214, 32'h0, 2, 1);
      add(1, 1, 32'h11111111, 1, 0, 0,  1, 32'h00188214, 32'h0, 3, 1);
      add(1, 1, 32'h22222222, 1, 0, 0,  1, 32'h00188214, 32'h0, 4, 0);
      add(1, 1, 32'h33333333, 1, 0, 0,  1, 32'h00188214, 32'h0, 4, 0);
      add(1, 0, 0, 0, 0, 0,             1, 32'h3402A084, 32'h4, 3, 1);
      add(1, 0, 0, 0, 0, 0,             1, 32'h11111111, 32'h8, 2, 1);
      add(1, 0, 0, 0, 0, 0,             1, 32'h22222222, 32'hC, 1, 1);
      add(1, 0, 0, 0, 0, 0,             0, 0, 0, 0, 1);
      // steady stream, push_pc continues from 0x10, pointers wrap
      for (int i = 0; i < 10; i++)
         add(1, 1, 32'h50000000 + 32'(i), 0, 0, 0,
             1, 32'h50000000 + 32'(i), 32'h10 + 32'(4 * i), 1, 1);
      add(1, 0, 0, 0, 0, 0,             0, 0, 0, 0, 1);
      // two queued, flush drops offered word, next push tagged with branch target
      add(1, 1, 32'h0A002080, 0, 0, 0,  1, 32'h0A002080, 32'h38, 1, 1);
      add(1, 1, 32'h00084004, 1, 0, 0,  1, 32'h0A002080, 32'h38, 2, 1);
      add(1, 1, 32'hDEADBEEF, 0, 1, 32'h100, 0, 0, 0, 0, 1);
      add(1, 1, 32'h00084004, 0, 0, 0,  1, 32'h00084004, 32'h100, 1, 1);
      add(1, 0, 0, 0, 0, 0,             0, 0, 0, 0, 1);
      // flush beats freeze with three queued
      add(1, 1, 32'h11111111, 1, 0, 0,  1, 32'h11111111, 32'h104, 1, 1);
      add(1, 1, 32'h22222222, 1, 0, 0,  1, 32'h11111111, 32'h104, 2, 1);
      add(1, 1, 32'h33333333, 1, 0, 0,  1, 32'h11111111, 32'h104, 3, 1);
      add(1, 0, 0, 1, 1, 32'h200,       0, 0, 0, 0, 1);
      add(1, 1, 32'h44444444, 0, 0, 0,  1, 32'h44444444, 32'h200, 1, 1);
      add(1, 0, 0, 0, 0, 0,             0, 0, 0, 0, 1);
      // mid-stream reset with three queued
      add(1, 1, 32'hAAAA0001, 1, 0, 0,  1, 32'hAAAA0001, 32'h204, 1, 1);
      add(1, 1, 32'hAAAA0002, 1, 0, 0,  1, 32'hAAAA0001, 32'h204, 2, 1);
      add(1, 1, 32'hAAAA0003, 1, 0, 0,  1, 32'hAAAA0001, 32'h204, 3, 1);
      add(0, 1, 32'hAAAA0004, 1, 0, 0,  0, 0, 0, 0, 1);
      add(1, 1, 32'h00084004, 0, 0, 0,  1, 32'h00084004, 32'h0, 1, 1);
      add(1, 0, 0, 0, 0, 0,             0, 0, 0, 0, 1);
      // PC wraps past 2^32
      add(1, 0, 0, 0, 1, 32'hFFFFFFFC,  0, 0, 0, 0, 1);
      add(1, 1, 32'h77770001, 1, 0, 0,  1, 32'h77770001, 32'hFFFFFFFC, 1, 1);
      add(1, 1, 32'h77770002, 0, 0, 0,  1, 32'h77770002, 32'h0, 1, 1);
      add(1, 0, 0, 0, 0, 0,             0, 0, 0, 0, 1);

      foreach (vecs[k]) begin
         drive(vecs[k].r, vecs[k].vin, vecs[k].ins, vecs[k].frz, vecs[k].fl, vecs[k].bt);
         check_outputs($sformatf("vec%0d", k), vecs[k].ev, vecs[k].ei, vecs[k].ep,
                       vecs[k].ec, vecs[k].er);
      end

      // randomized traffic against the reference queue
      mq.delete();
      mpc = 32'h0;
      drive(0, 0, 0, 0, 0, 0);
      for (int n = 0; n < 3000; n++) begin
         r   = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
         vin = ($urandom_range(0, 99) < 70);
         frz = ($urandom_range(0, 99) < 30);
         fl  = ($urandom_range(0, 99) < 5);
         ins = $urandom;
         bt  = $urandom & 32'hFFFFFFFC;
         if (!r) begin
            mq.delete();
            mpc = 32'h0;
         end else if (fl) begin
            mq.delete();
            mpc = bt;
         end else begin
            mready = (mq.size() < 4);
            mvalid = (mq.size() > 0);
            if (mvalid && !frz) void'(mq.pop_front());
            if (vin && mready) begin
               e.i = ins;
               e.p = mpc;
               mq.push_back(e);
               mpc = mpc + 32'd4;
            end
         end
         drive(r, vin, ins, frz, fl, bt);
         check_outputs($sformatf("rnd%0d", n), mq.size() > 0,
                       (mq.size() > 0) ? mq[0].i : 32'h0,
                       (mq.size() > 0) ? mq[0].p : 32'h0,
                       mq.size(), mq.size() < 4);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
